// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory round-robin arbiter.
//   arb_state_e : arbiter FSM state encoding
//   MEM_AW/DW   : geometry of the shared 32x8 single-port memory
//   rr_next()   : round-robin successor of a requester index
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, RDONE} arb_state_e;

  localparam int MEM_AW = 5;
  localparam int MEM_DW = 8;

  // Index that follows cur in an n-entry ring.
  function automatic int rr_next(input int cur, input int n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// mem_rr_arbiter_if: requester-side bus of the memory arbiter.
//   req/we/addr/wdata : per-requester command, held until done is seen
//   done              : one-hot completion pulse to the winner
//   rdata             : read data, valid with done of a read, held otherwise
//   busy              : arbiter not idle
// master = requesters, slave = arbiter.
interface mem_rr_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = MEM_AW,
  parameter int DW   = MEM_DW
);
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         we;
  logic [NREQ-1:0][AW-1:0] addr;
  logic [NREQ-1:0][DW-1:0] wdata;
  logic [NREQ-1:0]         done;
  logic [DW-1:0]           rdata;
  logic                    busy;

  modport master (output req, we, addr, wdata, input done, rdata, busy);
  modport slave  (input req, we, addr, wdata, output done, rdata, busy);
endinterface

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req : request vector
//   ptr : index with top priority this round
//   gnt : one-hot grant (all zero when no request)
//   win : index of the granted requester
//   any : at least one request present
// The winner is the requester with the smallest ring distance from ptr,
// which is the same as searching upward from ptr with wrap.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   win,
  output logic            any
);
  int best, best_d, d;

  always_comb begin
    best   = 0;
    best_d = NREQ;
    d      = 0;
    for (int j = 0; j < NREQ; j++) begin
      if (req[j]) begin
        d = (j + NREQ - int'(ptr)) % NREQ;
        if (d < best_d) begin
          best_d = d;
          best   = j;
        end
      end
    end
    any = (best_d < NREQ);
    gnt = '0;
    for (int j = 0; j < NREQ; j++) gnt[j] = any && (best == j);
    win = IW'(best);
  end
endmodule

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: shares one single-port memory among NREQ requesters.
//   clk, rst_n    : clock, async active-low reset
//   bus (slave)   : requester commands in, one-hot done / rdata / busy out
//   mem_read      : memory read strobe (ACCESS of a read)
//   mem_write     : memory write strobe (ACCESS of a write)
//   mem_addr      : latched address, holds when idle
//   mem_data_in   : latched write data, holds when idle
//   mem_data_out  : registered memory read data (1 cycle after mem_read)
// One access in flight. Write: IDLE->ACCESS(done). Read:
// IDLE->ACCESS->RDWAIT->RDONE(done). Pointer moves past the winner on done.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 2,   // 2..8
  parameter int AW   = MEM_AW,
  parameter int DW   = MEM_DW
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_rr_arbiter_if.slave  bus,
  output logic             mem_read,
  output logic             mem_write,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_data_in,
  input  logic [DW-1:0]    mem_data_out
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   ptr_q, win_q, pick_win;
  logic [NREQ-1:0] pick_gnt, done_c;
  logic            pick_any, cmd_we_q, complete, busy_c;
  logic [DW-1:0]   rdata_q;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .win (pick_win),
    .any (pick_any)
  );

  // AND-OR mux of the winner's fields; losers never reach the latch.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        sel_we    = sel_we | bus.we[i];
        sel_addr  = sel_addr | bus.addr[i];
        sel_wdata = sel_wdata | bus.wdata[i];
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_any) state_d = ACCESS;
      ACCESS:  state_d = cmd_we_q ? IDLE : RDWAIT;
      RDWAIT:  state_d = RDONE;
      RDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    mem_read  = (state_q == ACCESS) && !cmd_we_q;
    mem_write = (state_q == ACCESS) && cmd_we_q;
    complete  = mem_write || (state_q == RDONE);
    busy_c    = (state_q != IDLE);
    done_c    = complete ? ({{(NREQ-1){1'b0}}, 1'b1} << win_q) : '0;
  end

  assign bus.done  = done_c;
  assign bus.busy  = busy_c;
  assign bus.rdata = rdata_q;

  // command latch, read capture and rr pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_we_q    <= 1'b0;
      win_q       <= '0;
      ptr_q       <= '0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      rdata_q     <= '0;
    end else begin
      if (state_q == IDLE && pick_any) begin
        cmd_we_q    <= sel_we;
        win_q       <= pick_win;
        mem_addr    <= sel_addr;
        mem_data_in <= sel_wdata;
      end
      if (state_q == RDWAIT) rdata_q <= mem_data_out;
      if (complete) ptr_q <= IW'(rr_next(int'(win_q), NREQ));
    end
  end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
module tb_mem_rr_arbiter;
  import mem_arb_pkg::*;
  localparam int NREQ = 2;
  localparam int AW   = MEM_AW;
  localparam int DW   = MEM_DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in, mem_data_out;

  mem_rr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  mem_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  // environment memory (registered read)
  logic [DW-1:0] mem [32];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_data_in;
    if (mem_read)  mem_data_out <= mem[mem_addr];
  end

  // reference model: transaction level
  int            total = 0, bad = 0, cyc = 0, strobes = 0;
  int            m_left = 0, m_win = 0, ref_ptr = 0;
  logic          m_we = 1'b0, prev_wr = 1'b0;
  logic [AW-1:0] m_addr = '0, m_maddr = '0;
  logic [DW-1:0] m_wd = '0, m_rdata = '0;
  logic [DW-1:0] ref_mem [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: update model at posedge, compare at negedge
  task automatic step();
    int w, r;
    logic [NREQ-1:0] ed;
    @(posedge clk);
    cyc++;
    if (!rst_n) m_left = 0;
    else if (m_left == 0) begin
      w = -1;
      r = int'(bus.req);
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (ref_ptr + k) % NREQ;
        if (w < 0 && ((r >> idx) & 1) == 1) w = idx;
      end
      if (w >= 0) begin
        for (int j = 0; j < NREQ; j++) if (j == w) begin
          m_we = bus.we[j]; m_addr = bus.addr[j]; m_wd = bus.wdata[j];
        end
        m_win   = w;
        m_maddr = m_addr;
        m_left  = m_we ? 1 : 3;
        ref_ptr = (w + 1) % NREQ;
        if (m_we) ref_mem[m_addr] = m_wd;
      end
    end else begin
      m_left--;
      if (m_left == 1 && !m_we) m_rdata = ref_mem[m_addr];
    end
    @(negedge clk);
    ed = (m_left == 1) ? (NREQ'(1) << m_win) : '0;
    chk("busy", bus.busy, m_left != 0);
    chk("done", bus.done, ed);
    chk("mem_write", mem_write, m_left == 1 && m_we);
    chk("mem_read", mem_read, m_left == 3 && !m_we);
    chk("rdata", bus.rdata, m_rdata);
    chk("mem_addr", mem_addr, m_maddr);
    if (m_left == 1 && m_we) chk("mem_data_in", mem_data_in, m_wd);
    chk("wr_b2b", mem_write & prev_wr, 1'b0);
    prev_wr = mem_write;
    strobes += int'(mem_read) + int'(mem_write);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin step(); n++; end while (m_left != 1 && n < 30);
    if (m_left != 1) chk("done_timeout", m_left, 1);
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i] = 1'b1; bus.we[i] = w; bus.addr[i] = a; bus.wdata[i] = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, first;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    mem_data_out = '0;
    for (int a = 0; a < 32; a++) begin mem[a] = '0; ref_mem[a] = '0; end

    // 1. reset, then abandon a read mid-flight
    step(); step();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rdata", bus.rdata, 8'h00);
    rst_n = 1'b1;
    set_req(0, 1'b1, 5'h03, 8'h11);
    wait_done();
    chk("t1_pre", bus.done, 2'b01);
    bus.req[0] = 1'b0;
    step();
    set_req(1, 1'b0, 5'h03, 8'h00);
    step(); step();                       // in RDWAIT now
    rst_n = 1'b0;
    m_left = 0; ref_ptr = 0; m_rdata = '0; m_maddr = '0;
    bus.req = '0;
    step(); step();
    chk("t1_rst_done", bus.done, 2'b00);
    chk("t1_rst_addr", mem_addr, 5'h00);
    chk("t1_rst_rd", mem_read, 1'b0);
    rst_n = 1'b1;
    set_req(0, 1'b1, 5'h04, 8'h22);
    set_req(1, 1'b1, 5'h05, 8'h33);
    wait_done();
    chk("t1_first_gnt", bus.done, 2'b01);
    bus.req[0] = 1'b0;
    wait_done();
    chk("t1_second_gnt", bus.done, 2'b10);
    bus.req[1] = 1'b0;
    step();

    // 2. single write then read, requester 0
    set_req(0, 1'b1, 5'h0A, 8'h5C);
    c0 = cyc;
    wait_done();
    chk("t2_wr_lat", cyc - c0, 1);
    chk("t2_wr_done", bus.done, 2'b01);
    bus.req[0] = 1'b0;
    step();
    set_req(0, 1'b0, 5'h0A, 8'h00);
    c0 = cyc;
    wait_done();
    chk("t2_rd_lat", cyc - c0, 3);
    chk("t2_rd_done", bus.done, 2'b01);
    chk("t2_rdata", bus.rdata, 8'h5C);
    bus.req[0] = 1'b0;
    step();

    // 3. contention, all writes, req held
    set_req(0, 1'b1, 5'h10, 8'hAA);
    set_req(1, 1'b1, 5'h11, 8'hBB);
    first = ref_ptr;
    for (int k = 0; k < 4; k++) begin
      wait_done();
      chk("t3_alt", bus.done, 2'b01 << ((first + k) % 2));
    end
    bus.req = '0;
    step();

    // 4. read/write mix on 5'h1F
    set_req(1, 1'b1, 5'h1F, 8'h00);
    wait_done();
    bus.req[1] = 1'b0;
    step();
    set_req(0, 1'b0, 5'h1F, 8'h00);
    set_req(1, 1'b1, 5'h1F, 8'hA5);
    wait_done();
    chk("t4_first", bus.done, 2'b01);
    chk("t4_old", bus.rdata, 8'h00);
    bus.req[0] = 1'b0;
    wait_done();
    chk("t4_second", bus.done, 2'b10);
    bus.req[1] = 1'b0;
    step();
    set_req(0, 1'b0, 5'h1F, 8'h00);
    wait_done();
    chk("t4_new", bus.rdata, 8'hA5);
    bus.req[0] = 1'b0;
    step();

    // 5. sweep all addresses
    c0 = strobes;
    for (int a = 0; a < 32; a++) begin
      set_req(a % 2, 1'b1, AW'(a), DW'(a ^ 8'hFF));
      wait_done();
      bus.req = '0;
      step();
    end
    for (int a = 0; a < 32; a++) begin
      set_req(a % 2, 1'b0, AW'(a), 8'h00);
      wait_done();
      chk("t5_rd", bus.rdata, DW'(a ^ 8'hFF));
      bus.req = '0;
      step();
    end
    chk("t5_strobes", strobes - c0, 64);

    // 6. back-to-back from req0, req1 joins
    set_req(0, 1'b1, 5'h06, 8'h01);
    wait_done();
    chk("t6_first", bus.done, 2'b01);
    set_req(0, 1'b1, 5'h07, 8'h02);
    set_req(1, 1'b1, 5'h08, 8'h03);
    c0 = cyc;
    wait_done();
    chk("t6_gap", cyc - c0, 2);
    chk("t6_req1", bus.done, 2'b10);
    bus.req[1] = 1'b0;
    wait_done();
    chk("t6_req0", bus.done, 2'b01);
    bus.req = '0;
    step();

    // 7. random traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_left == 1 && m_win == i) begin
          if ($urandom_range(1) == 1)
            set_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
          else
            bus.req[i] = 1'b0;
        end else if (!bus.req[i] && $urandom_range(2) == 0) begin
          set_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
        end
      end
      step();
    end
    bus.req = '0;
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
